// File: rtl/dmx8_lane_reg.sv
// Registered 1-to-8 demultiplexer with per-lane valid flags and read-acknowledge.
// The target lane comes from the select input, or from a wrapping pointer in round-robin mode.
module dmx8_lane_reg #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               valid_in,
  input  logic [2:0]         s,
  input  logic               rr_mode,
  input  logic [7:0]         rd_ack,
  output logic               in_ready,
  output logic [8*WIDTH-1:0] y,
  output logic [7:0]         y_valid,
  output logic [2:0]         ptr,
  output logic               drop,
  output logic [3:0]         occ
);

  logic [8*WIDTH-1:0] laneData_q, laneData_d;
  logic [7:0]         laneValid_q, laneValid_d;
  logic [2:0]         ptr_q, ptr_d;
  logic               drop_q, drop_d;
  logic [3:0]         occ_q, occ_d;
  logic [2:0]         tgt;
  logic               wrEn;

  // A pending ack on the target lane frees it this cycle, so a write can replace the word at full rate.
  always_comb begin
    tgt      = rr_mode ? ptr_q : s;
    in_ready = ~laneValid_q[tgt] | rd_ack[tgt];
    wrEn     = valid_in & in_ready;
  end

  always_comb begin
    laneData_d  = laneData_q;
    laneValid_d = laneValid_q & ~rd_ack;
    ptr_d       = ptr_q;
    drop_d      = valid_in & ~in_ready;
    occ_d       = '0;
    if (wrEn) begin
      laneData_d[tgt*WIDTH +: WIDTH] = d_in;
      laneValid_d[tgt]               = 1'b1;
      if (rr_mode) begin
        ptr_d = ptr_q + 3'd1;
      end
    end
    // The count is taken from the next-state flags so that it stays in step with y_valid.
    for (int i = 0; i < 8; i++) begin
      occ_d = occ_d + {3'b000, laneValid_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      laneData_q  <= '0;
      laneValid_q <= '0;
      ptr_q       <= '0;
      drop_q      <= 1'b0;
      occ_q       <= '0;
    end else begin
      laneData_q  <= laneData_d;
      laneValid_q <= laneValid_d;
      ptr_q       <= ptr_d;
      drop_q      <= drop_d;
      occ_q       <= occ_d;
    end
  end

  assign y       = laneData_q;
  assign y_valid = laneValid_q;
  assign ptr     = ptr_q;
  assign drop    = drop_q;
  assign occ     = occ_q;

endmodule

// File: tb/tb_dmx8_lane_reg.sv
// Directed testbench for dmx8_lane_reg. Each scenario task drives its own vectors
// and checks them against hand-computed values.
module tb_dmx8_lane_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  d_in;
  logic        valid_in;
  logic [2:0]  s;
  logic        rr_mode;
  logic [7:0]  rd_ack;
  logic        in_ready;
  logic [31:0] y;
  logic [7:0]  y_valid;
  logic [2:0]  ptr;
  logic        drop;
  logic [3:0]  occ;

  int total = 0;
  int bad   = 0;

  dmx8_lane_reg #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .valid_in(valid_in), .s(s),
    .rr_mode(rr_mode), .rd_ack(rd_ack), .in_ready(in_ready), .y(y),
    .y_valid(y_valid), .ptr(ptr), .drop(drop), .occ(occ)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] laneOf(input int i);
    return y[i*4 +: 4];
  endfunction

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b1; d_in = 4'hF; s = 3'd0; rr_mode = 1'b0; rd_ack = 8'h00;
    tick();
    tick();
    total++; if (y !== 32'h0) begin bad++; $display("[TB] FAIL reset_y got=%h exp=%h", y, 32'h0); end
    total++; if (y_valid !== 8'h00) begin bad++; $display("[TB] FAIL reset_yvalid got=%h exp=%h", y_valid, 8'h00); end
    total++; if (ptr !== 3'd0) begin bad++; $display("[TB] FAIL reset_ptr got=%0d exp=%0d", ptr, 0); end
    total++; if (occ !== 4'd0) begin bad++; $display("[TB] FAIL reset_occ got=%0d exp=%0d", occ, 0); end
    total++; if (drop !== 1'b0) begin bad++; $display("[TB] FAIL reset_drop got=%b exp=%b", drop, 1'b0); end
    reset = 1'b0; valid_in = 1'b0;
  endtask

  task automatic test_addressed();
    rr_mode = 1'b0; s = 3'd5; d_in = 4'hA; valid_in = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL addr_inready got=%b exp=%b", in_ready, 1'b1); end
    tick();
    valid_in = 1'b0;
    total++; if (laneOf(5) !== 4'hA) begin bad++; $display("[TB] FAIL addr_lane5 got=%h exp=%h", laneOf(5), 4'hA); end
    total++; if (y_valid !== 8'b0010_0000) begin bad++; $display("[TB] FAIL addr_yvalid got=%b exp=%b", y_valid, 8'b0010_0000); end
    total++; if (occ !== 4'd1) begin bad++; $display("[TB] FAIL addr_occ got=%0d exp=%0d", occ, 1); end
    total++; if (ptr !== 3'd0) begin bad++; $display("[TB] FAIL addr_ptr got=%0d exp=%0d", ptr, 0); end
    rd_ack = 8'hFF;
    tick();
    rd_ack = 8'h00;
    total++; if (y_valid !== 8'h00) begin bad++; $display("[TB] FAIL addr_read_yvalid got=%h exp=%h", y_valid, 8'h00); end
    total++; if (laneOf(5) !== 4'hA) begin bad++; $display("[TB] FAIL addr_read_retain got=%h exp=%h", laneOf(5), 4'hA); end
    total++; if (occ !== 4'd0) begin bad++; $display("[TB] FAIL addr_read_occ got=%0d exp=%0d", occ, 0); end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] word;
    logic [2:0] lane;
    logic [7:0] expValid;
    rr_mode = 1'b1; rd_ack = 8'hFF; valid_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      word = k[3:0];
      lane = 3'((k - 1) % 8);
      expValid = 8'h01 << lane;
      d_in = word;
      #1;
      total++; if (ptr !== lane) begin bad++; $display("[TB] FAIL rr_ptr_%0d got=%0d exp=%0d", k, ptr, lane); end
      tick();
      total++; if (laneOf(int'(lane)) !== word) begin bad++; $display("[TB] FAIL rr_lane_%0d got=%h exp=%h", k, laneOf(int'(lane)), word); end
      total++; if (y_valid !== expValid) begin bad++; $display("[TB] FAIL rr_yvalid_%0d got=%b exp=%b", k, y_valid, expValid); end
      total++; if (drop !== 1'b0) begin bad++; $display("[TB] FAIL rr_drop_%0d got=%b exp=%b", k, drop, 1'b0); end
    end
    valid_in = 1'b0;
    total++; if (ptr !== 3'd1) begin bad++; $display("[TB] FAIL rr_ptr_final got=%0d exp=%0d", ptr, 1); end
    total++; if (laneOf(1) !== 4'h2) begin bad++; $display("[TB] FAIL rr_lane1_retain got=%h exp=%h", laneOf(1), 4'h2); end
    tick();
    rd_ack = 8'h00;
    total++; if (occ !== 4'd0) begin bad++; $display("[TB] FAIL rr_drain_occ got=%0d exp=%0d", occ, 0); end
  endtask

  task automatic test_full_drop();
    rr_mode = 1'b0; rd_ack = 8'h00; valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      d_in = 4'(i + 8);
      tick();
    end
    valid_in = 1'b0;
    total++; if (occ !== 4'd8) begin bad++; $display("[TB] FAIL full_occ got=%0d exp=%0d", occ, 8); end
    total++; if (y_valid !== 8'hFF) begin bad++; $display("[TB] FAIL full_yvalid got=%h exp=%h", y_valid, 8'hFF); end
    s = 3'd2; d_in = 4'h7; valid_in = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_inready got=%b exp=%b", in_ready, 1'b0); end
    tick();
    valid_in = 1'b0;
    total++; if (drop !== 1'b1) begin bad++; $display("[TB] FAIL full_drop got=%b exp=%b", drop, 1'b1); end
    total++; if (laneOf(2) !== 4'hA) begin bad++; $display("[TB] FAIL full_lane2 got=%h exp=%h", laneOf(2), 4'hA); end
    total++; if (occ !== 4'd8) begin bad++; $display("[TB] FAIL full_occ_after got=%0d exp=%0d", occ, 8); end
    total++; if (ptr !== 3'd1) begin bad++; $display("[TB] FAIL full_ptr got=%0d exp=%0d", ptr, 1); end
    tick();
    total++; if (drop !== 1'b0) begin bad++; $display("[TB] FAIL full_drop_clear got=%b exp=%b", drop, 1'b0); end
  endtask

  task automatic test_ack_write();
    rr_mode = 1'b0; s = 3'd3; rd_ack = 8'h08; valid_in = 1'b1; d_in = 4'h1;
    tick();
    total++; if (laneOf(3) !== 4'h1) begin bad++; $display("[TB] FAIL aw_lane3_first got=%h exp=%h", laneOf(3), 4'h1); end
    d_in = 4'h2;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL aw_inready got=%b exp=%b", in_ready, 1'b1); end
    tick();
    valid_in = 1'b0; rd_ack = 8'h00;
    total++; if (laneOf(3) !== 4'h2) begin bad++; $display("[TB] FAIL aw_lane3 got=%h exp=%h", laneOf(3), 4'h2); end
    total++; if (y_valid !== 8'hFF) begin bad++; $display("[TB] FAIL aw_yvalid got=%h exp=%h", y_valid, 8'hFF); end
    total++; if (occ !== 4'd8) begin bad++; $display("[TB] FAIL aw_occ got=%0d exp=%0d", occ, 8); end
    total++; if (drop !== 1'b0) begin bad++; $display("[TB] FAIL aw_drop got=%b exp=%b", drop, 1'b0); end
    rd_ack = 8'b1010_0101;
    tick();
    total++; if (y_valid !== 8'h5A) begin bad++; $display("[TB] FAIL multi_ack_yvalid got=%h exp=%h", y_valid, 8'h5A); end
    total++; if (occ !== 4'd4) begin bad++; $display("[TB] FAIL multi_ack_occ got=%0d exp=%0d", occ, 4); end
    rd_ack = 8'h01;
    tick();
    rd_ack = 8'h00;
    total++; if (y_valid !== 8'h5A) begin bad++; $display("[TB] FAIL empty_ack_yvalid got=%h exp=%h", y_valid, 8'h5A); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0; rr_mode = 1'b1; rd_ack = 8'h00; valid_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_in = 4'(i + 3);
      tick();
    end
    valid_in = 1'b0; rd_ack = 8'h01;
    tick();
    rd_ack = 8'h00;
    total++; if (occ !== 4'd5) begin bad++; $display("[TB] FAIL mid_pre_occ got=%0d exp=%0d", occ, 5); end
    total++; if (ptr !== 3'd6) begin bad++; $display("[TB] FAIL mid_pre_ptr got=%0d exp=%0d", ptr, 6); end
    reset = 1'b1; valid_in = 1'b1; d_in = 4'hF; rd_ack = 8'hFF;
    tick();
    reset = 1'b0; valid_in = 1'b0; rd_ack = 8'h00;
    total++; if (y !== 32'h0) begin bad++; $display("[TB] FAIL mid_y got=%h exp=%h", y, 32'h0); end
    total++; if (y_valid !== 8'h00) begin bad++; $display("[TB] FAIL mid_yvalid got=%h exp=%h", y_valid, 8'h00); end
    total++; if (ptr !== 3'd0) begin bad++; $display("[TB] FAIL mid_ptr got=%0d exp=%0d", ptr, 0); end
    total++; if (occ !== 4'd0) begin bad++; $display("[TB] FAIL mid_occ got=%0d exp=%0d", occ, 0); end
    total++; if (drop !== 1'b0) begin bad++; $display("[TB] FAIL mid_drop got=%b exp=%b", drop, 1'b0); end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; d_in = 4'h0; s = 3'd0; rr_mode = 1'b0; rd_ack = 8'h00;
    #1;
    test_reset();
    test_addressed();
    test_rr_wrap();
    test_full_drop();
    test_ack_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
